weight_fetch_ctrl: RTL and testbench
====================================

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 SHALL have parameter numWeight, default 784: number of weights per neuron pass, 1..2**addressWidth.
REQ-002 SHALL have parameter addressWidth, default 10: weight memory address parameter; raddr is addressWidth+1 bits.
REQ-003 SHALL have parameter dataWidth, default 16: weight and input sample width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1: begin one pass; sampled only in IDLE.
REQ-007 SHALL have port clear  input  1: synchronous abort; returns to IDLE and flushes.
REQ-008 SHALL have port busy  output  1: high in every state except IDLE.
REQ-009 SHALL have port done  output  1: one-cycle pulse at pass completion.
REQ-010 SHALL have ports in_valid input 1, in_ready output 1, in_data input dataWidth: input sample stream.
REQ-011 SHALL have ports mem_ren output 1, mem_raddr output addressWidth+1, mem_rdata input dataWidth: weight memory read port; rdata valid exactly 1 cycle after ren.
REQ-012 SHALL have ports out_valid output 1, out_ready input 1, out_x output dataWidth, out_w output dataWidth, out_last output 1: paired (sample, weight) stream to the MAC.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-014 SHALL transition IDLE->FETCH when start=1; start SHALL be ignored in other states.
REQ-015 SHALL, on entering FETCH, set the issue count and mem_raddr to 0.
REQ-016 SHALL drive in_ready = (state==FETCH) && (issued < numWeight) && (inflight + fifo occupancy < 2).
REQ-017 SHALL, on an in_valid&&in_ready cycle, assert mem_ren for that cycle, present mem_raddr = issued, register in_data, and increment issued.
REQ-018 SHALL keep mem_ren=0 on all other cycles.
REQ-019 SHALL, one cycle after a read, push {registered in_data, mem_rdata, last flag} into a 2-entry FIFO; last flag = (pair index == numWeight-1).
REQ-020 SHALL, from the FIFO head, drive out_valid, out_x, out_w and out_last; a pop occurs on out_valid&&out_ready.
REQ-021 SHALL hold out_x/out_w/out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL never overflow the FIFO; the credit rule of REQ-016 makes it so with out_ready held low indefinitely.
REQ-023 SHALL transition FETCH->DRAIN in the cycle after issued reaches numWeight.
REQ-024 SHALL transition DRAIN->DONE on the pop of the out_last pair.
REQ-025 SHALL, in DONE, pulse done=1 for one cycle, then go to IDLE.
REQ-026 SHALL, for numWeight=1, issue one read, go FETCH->DRAIN, and mark the single pair as last.
REQ-027 SHALL, when clear=1 in any state, go to IDLE next cycle, empty the FIFO, discard any in-flight read, and drop in_ready and out_valid; done SHALL not pulse.
REQ-028 SHALL give clear priority over start in the same cycle.
REQ-029 SHALL keep mem_raddr at 0 when not reading and SHALL never drive mem_raddr >= numWeight.
REQ-030 SHALL have a sample-to-pair latency of 2 cycles: handshake in cycle N gives out_valid in cycle N+2 when the FIFO is empty.

Reset
REQ-031 SHALL, while rst_n=0, set state=IDLE, issued=0, FIFO empty, and busy, done, in_ready, mem_ren, out_valid, out_last=0, mem_raddr=0, out_x=out_w=0.
REQ-032 SHALL resume from IDLE after rst_n is released, including when reset is asserted mid-pass; no pair from the aborted pass SHALL appear.

Structure
REQ-033 SHALL place the FSM state encoding and the FIFO depth constant (2) in the shared package elm_pkg.
REQ-034 SHALL implement the 2-entry FIFO as sub-module pair_fifo2, which has push, pop, flush, full, empty and count, and holds data of width 2*dataWidth+1.

Verification
REQ-035 SHALL test: numWeight=4, in_valid=1 continuously, out_ready=1 -> raddr 0,1,2,3 on consecutive cycles; four pairs; out_last on the 4th pair; done is a single pulse; busy drops afterward.
REQ-036 SHALL test: out_ready=0 for 10 cycles mid-pass -> in_ready drops at 2 pairs outstanding; no pair is lost or duplicated; out_x/out_w stay stable.
REQ-037 SHALL test: in_valid toggled 1,0,1,0 -> mem_ren asserts only on handshake cycles; pairs match sample order with mem contents.
REQ-038 SHALL test: clear asserted after 2 of 4 reads -> IDLE next cycle; FIFO empty; no done; a new start gives raddr restarting at 0.
REQ-039 SHALL test: rst_n low mid-DRAIN -> all outputs 0 asynchronously; clean pass after release.
REQ-040 SHALL test: numWeight=1 and start held high in DONE -> one pair with out_last=1; a second pass starts only from IDLE.

Source files
------------

// File: rtl/elm_pkg.sv
// Shared state encoding and FIFO sizing for the weight fetch controller.
package elm_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/pair_fifo2.sv
// Two-entry FIFO holding {sample, weight, last} pairs between the weight read and the MAC.
module pair_fifo2 import elm_pkg::*; #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'(FIFO_DEPTH));
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/weight_fetch_ctrl.sv
// Pairs each input sample with its weight read from memory and streams the pairs to the MAC.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | accepting samples and issuing weight reads
//   DRAIN | all reads issued, emptying the pair FIFO
//   DONE  | one-cycle completion pulse
module weight_fetch_ctrl import elm_pkg::*; #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [dataWidth-1:0]  in_data,
    output logic                  mem_ren,
    output logic [addressWidth:0] mem_raddr,
    input  logic [dataWidth-1:0]  mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dataWidth-1:0]  out_x,
    output logic [dataWidth-1:0]  out_w,
    output logic                  out_last
);
    localparam int PW = 2*dataWidth + 1;
    localparam logic [addressWidth:0] NUM_W    = (addressWidth+1)'(numWeight);
    localparam logic [addressWidth:0] LAST_IDX = (addressWidth+1)'(numWeight - 1);
    localparam logic [addressWidth:0] ONE      = (addressWidth+1)'(1);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [addressWidth:0] issued;
    logic                  rd_pending;
    logic                  rd_last;
    logic [dataWidth-1:0]  x_hold;
    logic                  hs;
    logic                  pop;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic [2:0]            credit_used;
    logic [PW-1:0]         fifo_din;
    logic [PW-1:0]         fifo_dout;

    // A pair popped this cycle frees its slot, so a streaming consumer sees one pair per cycle.
    assign pop         = out_valid && out_ready;
    assign credit_used = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
    assign in_ready    = (state == FETCH) && (issued < NUM_W) && (credit_used < 3'd2);
    assign hs          = in_valid && in_ready;
    assign mem_ren     = hs;
    assign mem_raddr   = hs ? issued : '0;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    assign fifo_push = rd_pending && (!fifo_full || pop);
    assign fifo_din  = {x_hold, mem_rdata, rd_last};
    assign out_valid = !fifo_empty;
    assign out_x     = fifo_dout[PW-1 -: dataWidth];
    assign out_w     = fifo_dout[dataWidth:1];
    assign out_last  = out_valid && fifo_dout[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issued     <= '0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
            x_hold     <= '0;
        end else begin
            state <= state_nxt;
            if (clear || state == IDLE) begin
                issued <= '0;
            end else if (hs) begin
                issued <= issued + ONE;
            end
            rd_pending <= hs && !clear;
            if (hs) begin
                x_hold  <= in_data;
                rd_last <= (issued == LAST_IDX);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = FETCH;
                FETCH:   if (issued == NUM_W) state_nxt = DRAIN;
                DRAIN:   if (pop && out_last) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    pair_fifo2 #(.W(PW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (pop),
        .flush (clear),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: a 4-weight instance for most scenarios and a 1-weight instance.
module tb_weight_fetch_ctrl;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NW = 4;
    localparam int PW = 2*DW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_start, a_clear, a_busy, a_done, a_in_valid, a_in_ready;
    logic          a_mem_ren, a_out_valid, a_out_ready, a_out_last;
    logic [DW-1:0] a_in_data, a_mem_rdata, a_out_x, a_out_w;
    logic [AW:0]   a_mem_raddr;
    logic          b_start, b_clear, b_busy, b_done, b_in_valid, b_in_ready;
    logic          b_mem_ren, b_out_valid, b_out_ready, b_out_last;
    logic [DW-1:0] b_in_data, b_mem_rdata, b_out_x, b_out_w;
    logic [AW:0]   b_mem_raddr;

    logic [DW-1:0] wmem_a [NW];
    logic [DW-1:0] wmem_b;
    logic [DW-1:0] samples [NW];

    int n_pass  = 0;
    int n_total = 0;

    logic [PW-1:0] obs_pairs[$];
    int obs_raddr[$];
    int obs_hs_cyc[$];
    int ren_bad, ready_bad, stable_bad, busy_bad, done_cnt, peak_out;
    int first_hs, first_ov, last_pop, done_cyc;

    weight_fetch_ctrl #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .clear(a_clear), .busy(a_busy), .done(a_done),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .mem_ren(a_mem_ren), .mem_raddr(a_mem_raddr), .mem_rdata(a_mem_rdata),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_x(a_out_x), .out_w(a_out_w),
        .out_last(a_out_last)
    );

    weight_fetch_ctrl #(.numWeight(1), .addressWidth(AW), .dataWidth(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .clear(b_clear), .busy(b_busy), .done(b_done),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .mem_ren(b_mem_ren), .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_x(b_out_x), .out_w(b_out_w),
        .out_last(b_out_last)
    );

    // Weight memories: read data one cycle after the read strobe.
    always @(posedge clk) begin
        if (a_mem_ren) a_mem_rdata <= (a_mem_raddr < 11'(NW)) ? wmem_a[a_mem_raddr[1:0]] : 16'hdead;
        if (b_mem_ren) b_mem_rdata <= (b_mem_raddr == 11'd0) ? wmem_b : 16'hdead;
    end

    // One pass on instance a. vmode: 0 valid always, 1 alternate, 2 random.
    // rmode: 0 ready always, 1 stall window, 2 random. Only records observations.
    task automatic run_pass(input int vmode, input int rmode, input int stall_at, input int stall_len);
        int sent, outst;
        logic hs, popped, exp_rdy, prev_stall;
        logic [PW-1:0] prev_head;
        obs_pairs.delete(); obs_raddr.delete(); obs_hs_cyc.delete();
        ren_bad = 0; ready_bad = 0; stable_bad = 0; busy_bad = 0; done_cnt = 0; peak_out = 0;
        first_hs = -1; first_ov = -1; last_pop = -1; done_cyc = -1;
        for (int i = 0; i < NW; i++) samples[i] = DW'($urandom);
        @(negedge clk);
        a_start = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        sent = 0; outst = 0; prev_stall = 1'b0; prev_head = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            case (vmode)
                0:       a_in_valid = (sent < NW);
                1:       a_in_valid = (sent < NW) && (cyc % 2 == 0);
                default: a_in_valid = (sent < NW) && ($urandom_range(0, 1) == 1);
            endcase
            a_in_data = (sent < NW) ? samples[sent] : '0;
            case (rmode)
                0:       a_out_ready = 1'b1;
                1:       a_out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
                default: a_out_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            hs     = a_in_valid && a_in_ready;
            popped = a_out_valid && a_out_ready;
            exp_rdy = (sent < NW) && ((outst - (popped ? 1 : 0)) < 2);
            if (a_in_ready !== exp_rdy) ready_bad++;
            if (a_mem_ren !== hs) ren_bad++;
            if (hs) begin
                obs_raddr.push_back(int'(a_mem_raddr));
                obs_hs_cyc.push_back(cyc);
                if (first_hs < 0) first_hs = cyc;
                sent++;
                outst++;
            end else if (a_mem_raddr !== '0) begin
                ren_bad++;
            end
            if (prev_stall && (!a_out_valid || {a_out_x, a_out_w, a_out_last} !== prev_head)) stable_bad++;
            prev_stall = a_out_valid && !a_out_ready;
            prev_head  = {a_out_x, a_out_w, a_out_last};
            if (a_out_valid && first_ov < 0) first_ov = cyc;
            if (popped) begin
                obs_pairs.push_back({a_out_x, a_out_w, a_out_last});
                outst--;
                last_pop = cyc;
            end
            if (outst > peak_out) peak_out = outst;
            if (a_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0 || cyc == done_cyc) begin
                if (a_busy !== 1'b1) busy_bad++;
            end else if (a_busy !== 1'b0) begin
                busy_bad++;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if ({a_busy, a_done, a_in_ready, a_mem_ren, a_out_valid, a_out_last, a_mem_raddr, a_out_x, a_out_w} !== '0)
            $display("FAIL reset_a: outputs %h required 0", {a_busy, a_done, a_in_ready, a_mem_ren,
                     a_out_valid, a_out_last, a_mem_raddr, a_out_x, a_out_w});
        else n_pass++;
        n_total++;
        if ({b_busy, b_done, b_in_ready, b_mem_ren, b_out_valid, b_out_last, b_mem_raddr, b_out_x, b_out_w} !== '0)
            $display("FAIL reset_b: outputs %h required 0", {b_busy, b_done, b_in_ready, b_mem_ren,
                     b_out_valid, b_out_last, b_mem_raddr, b_out_x, b_out_w});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [PW-1:0] got, exp;
        for (int i = 0; i < NW; i++) wmem_a[i] = DW'($urandom);
        run_pass(0, 0, 0, 0);
        for (int i = 0; i < NW; i++) begin
            n_total++;
            if (i >= obs_raddr.size() || obs_raddr[i] != i)
                $display("FAIL basic_raddr[%0d]: got %0d required %0d", i, (i < obs_raddr.size()) ? obs_raddr[i] : -1, i);
            else n_pass++;
        end
        n_total++;
        if (obs_hs_cyc.size() != NW || obs_hs_cyc[NW-1] - obs_hs_cyc[0] != NW - 1)
            $display("FAIL basic_consecutive: got %0d reads spread over span required %0d in %0d cycles",
                     obs_hs_cyc.size(), NW, NW);
        else n_pass++;
        n_total++;
        if (obs_pairs.size() != NW) $display("FAIL basic_pair_count: got %0d required %0d", obs_pairs.size(), NW);
        else n_pass++;
        for (int i = 0; i < NW; i++) begin
            exp = {samples[i], wmem_a[i], (i == NW - 1)};
            got = (i < obs_pairs.size()) ? obs_pairs[i] : 'x;
            n_total++;
            if (got !== exp) $display("FAIL basic_pair[%0d]: got %h required %h", i, got, exp);
            else n_pass++;
        end
        n_total++;
        if (done_cnt != 1 || done_cyc != last_pop + 1)
            $display("FAIL basic_done: got %0d pulses at %0d required 1 at %0d", done_cnt, done_cyc, last_pop + 1);
        else n_pass++;
        n_total++;
        if (busy_bad != 0) $display("FAIL basic_busy: got %0d bad cycles required 0", busy_bad);
        else n_pass++;
        n_total++;
        if (first_ov - first_hs != 2) $display("FAIL basic_latency: got %0d required 2", first_ov - first_hs);
        else n_pass++;
        n_total++;
        if (ren_bad != 0 || ready_bad != 0)
            $display("FAIL basic_ren_ready: got %0d/%0d bad cycles required 0/0", ren_bad, ready_bad);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] got, exp;
        for (int i = 0; i < NW; i++) wmem_a[i] = DW'($urandom);
        run_pass(0, 1, 1, 10);
        n_total++;
        if (peak_out != 2 || ready_bad != 0)
            $display("FAIL bp_credit: got peak %0d with %0d bad in_ready cycles required peak 2 and 0", peak_out, ready_bad);
        else n_pass++;
        n_total++;
        if (stable_bad != 0) $display("FAIL bp_stable: got %0d unstable cycles required 0", stable_bad);
        else n_pass++;
        n_total++;
        if (obs_pairs.size() != NW) $display("FAIL bp_pair_count: got %0d required %0d", obs_pairs.size(), NW);
        else n_pass++;
        for (int i = 0; i < NW; i++) begin
            exp = {samples[i], wmem_a[i], (i == NW - 1)};
            got = (i < obs_pairs.size()) ? obs_pairs[i] : 'x;
            n_total++;
            if (got !== exp) $display("FAIL bp_pair[%0d]: got %h required %h", i, got, exp);
            else n_pass++;
        end
        n_total++;
        if (done_cnt != 1) $display("FAIL bp_done: got %0d pulses required 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_valid_toggle();
        logic [PW-1:0] got, exp;
        for (int i = 0; i < NW; i++) wmem_a[i] = DW'($urandom);
        run_pass(1, 0, 0, 0);
        n_total++;
        if (ren_bad != 0) $display("FAIL toggle_ren: got %0d bad cycles required 0", ren_bad);
        else n_pass++;
        n_total++;
        if (obs_pairs.size() != NW) $display("FAIL toggle_pair_count: got %0d required %0d", obs_pairs.size(), NW);
        else n_pass++;
        for (int i = 0; i < NW; i++) begin
            exp = {samples[i], wmem_a[i], (i == NW - 1)};
            got = (i < obs_pairs.size()) ? obs_pairs[i] : 'x;
            n_total++;
            if (got !== exp) $display("FAIL toggle_pair[%0d]: got %h required %h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] got, exp;
        int bad;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < NW; i++) wmem_a[i] = DW'($urandom);
            run_pass(2, 2, 0, 0);
            bad = 0;
            for (int i = 0; i < NW; i++) begin
                exp = {samples[i], wmem_a[i], (i == NW - 1)};
                got = (i < obs_pairs.size()) ? obs_pairs[i] : 'x;
                if (got !== exp) bad++;
            end
            n_total++;
            if (bad != 0 || obs_pairs.size() != NW)
                $display("FAIL rand_pairs[%0d]: got %0d pairs with %0d wrong required %0d correct", p, obs_pairs.size(), bad, NW);
            else n_pass++;
            n_total++;
            if (ren_bad + ready_bad + stable_bad + busy_bad != 0 || done_cnt != 1)
                $display("FAIL rand_protocol[%0d]: got ren %0d ready %0d stable %0d busy %0d done %0d required 0 0 0 0 1",
                         p, ren_bad, ready_bad, stable_bad, busy_bad, done_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        logic [PW-1:0] got, exp;
        int n, bad;
        @(negedge clk);
        a_start = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b0; a_in_data = DW'($urandom);
        @(negedge clk);
        a_start = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (a_in_valid && a_in_ready) n++;
        end
        @(negedge clk);
        a_clear = 1'b1; a_in_valid = 1'b0;
        @(negedge clk);
        a_clear = 1'b0;
        #1;
        n_total++;
        if ({a_busy, a_in_ready, a_out_valid, a_done} !== 4'b0000)
            $display("FAIL clear_idle: got busy/in_ready/out_valid/done %b required 0000",
                     {a_busy, a_in_ready, a_out_valid, a_done});
        else n_pass++;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (a_out_valid !== 1'b0 || a_done !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL clear_flushed: got %0d cycles with stale pair or done required 0", bad);
        else n_pass++;
        for (int i = 0; i < NW; i++) wmem_a[i] = DW'($urandom);
        run_pass(0, 0, 0, 0);
        n_total++;
        if (obs_raddr.size() == 0 || obs_raddr[0] != 0)
            $display("FAIL clear_restart_raddr: got %0d required 0", (obs_raddr.size() > 0) ? obs_raddr[0] : -1);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < NW; i++) begin
            exp = {samples[i], wmem_a[i], (i == NW - 1)};
            got = (i < obs_pairs.size()) ? obs_pairs[i] : 'x;
            if (got !== exp) bad++;
        end
        n_total++;
        if (bad != 0 || obs_pairs.size() != NW)
            $display("FAIL clear_restart_pairs: got %0d pairs with %0d wrong required %0d correct", obs_pairs.size(), bad, NW);
        else n_pass++;
    endtask

    task automatic test_reset_drain();
        logic [PW-1:0] got, exp;
        int n, bad;
        @(negedge clk);
        a_start = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1; a_in_data = DW'($urandom);
        @(negedge clk);
        a_start = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (a_in_valid && a_in_ready) n++;
            if (n == NW) break;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_total++;
        if ({a_busy, a_out_valid} !== 2'b11)
            $display("FAIL drain_before_reset: got busy/out_valid %b required 11", {a_busy, a_out_valid});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({a_busy, a_done, a_in_ready, a_mem_ren, a_out_valid, a_out_last, a_mem_raddr, a_out_x, a_out_w} !== '0)
            $display("FAIL drain_async_reset: outputs %h required 0", {a_busy, a_done, a_in_ready, a_mem_ren,
                     a_out_valid, a_out_last, a_mem_raddr, a_out_x, a_out_w});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) wmem_a[i] = DW'($urandom);
        run_pass(0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < NW; i++) begin
            exp = {samples[i], wmem_a[i], (i == NW - 1)};
            got = (i < obs_pairs.size()) ? obs_pairs[i] : 'x;
            if (got !== exp) bad++;
        end
        n_total++;
        if (bad != 0 || obs_pairs.size() != NW || done_cnt != 1)
            $display("FAIL drain_clean_pass: got %0d pairs, %0d wrong, %0d done required %0d, 0, 1",
                     obs_pairs.size(), bad, done_cnt, NW);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [DW-1:0] sample;
        logic [PW-1:0] first_pair;
        logic          busy_v [12];
        logic          done_v [12];
        int npairs, dcyc, pcyc, nreads, raddr0;
        wmem_b = DW'($urandom);
        sample = DW'($urandom);
        npairs = 0; dcyc = -1; pcyc = -1; nreads = 0; raddr0 = -1; first_pair = 'x;
        @(negedge clk);
        b_start = 1'b1; b_in_valid = 1'b1; b_in_data = sample; b_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            busy_v[c] = b_busy;
            done_v[c] = b_done;
            if (b_mem_ren && dcyc < 0) begin
                nreads++;
                if (raddr0 < 0) raddr0 = int'(b_mem_raddr);
            end
            if (b_out_valid && b_out_ready && dcyc < 0) begin
                npairs++;
                if (pcyc < 0) begin
                    pcyc = c;
                    first_pair = {b_out_x, b_out_w, b_out_last};
                end
            end
            if (b_done === 1'b1 && dcyc < 0) dcyc = c;
        end
        @(negedge clk);
        b_start = 1'b0; b_in_valid = 1'b0; b_clear = 1'b1;
        @(negedge clk);
        b_clear = 1'b0;
        n_total++;
        if (nreads != 1 || raddr0 != 0)
            $display("FAIL single_read: got %0d reads first addr %0d required 1 at 0", nreads, raddr0);
        else n_pass++;
        n_total++;
        if (npairs != 1 || first_pair !== {sample, wmem_b, 1'b1})
            $display("FAIL single_pair: got %0d pairs first %h required 1 pair %h", npairs, first_pair, {sample, wmem_b, 1'b1});
        else n_pass++;
        n_total++;
        if (dcyc < 0 || dcyc > 9 || dcyc != pcyc + 1)
            $display("FAIL single_done_time: got done at %0d required %0d", dcyc, pcyc + 1);
        else n_pass++;
        n_total++;
        if (dcyc < 0 || dcyc > 9 || {done_v[dcyc+1], busy_v[dcyc+1], busy_v[dcyc+2]} !== 3'b001)
            $display("FAIL single_restart_from_idle: got done/busy/busy %b required 001",
                     (dcyc >= 0 && dcyc <= 9) ? {done_v[dcyc+1], busy_v[dcyc+1], busy_v[dcyc+2]} : 3'bxxx);
        else n_pass++;
    endtask

    initial begin
        a_start = 1'b0; a_clear = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_start = 1'b0; b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        wmem_b = '0;
        for (int i = 0; i < NW; i++) wmem_a[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_valid_toggle();
        test_random();
        test_clear();
        test_reset_drain();
        test_single();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end
endmodule
